// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and helpers for the ALU instruction sequencer.
// Holds the sequencer state enum, the packed instruction layout
// (op | rs | rt | rd) and the field-extract helper used by the top.
package alu_seq_pkg;

  // Field widths of the packed register-register instruction word.
  localparam int OP_W    = 3;
  localparam int ADDR_W  = 5;
  localparam int INSTR_W = 18;

  // Least-significant bit of each field inside the instruction word.
  localparam int OP_LSB = 15;
  localparam int RS_LSB = 10;
  localparam int RT_LSB = 5;
  localparam int RD_LSB = 0;

  // Sequencer states: wait for work, drive reads/ALU, commit the write.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WRITE = 2'd2
  } state_t;

  // Decoded view of one instruction.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [ADDR_W-1:0] rd;
  } instr_t;

  // Split a packed instruction word into its named fields.
  function automatic instr_t instr_unpack(input logic [INSTR_W-1:0] word);
    instr_t fields;
    fields.op = word[OP_LSB +: OP_W];
    fields.rs = word[RS_LSB +: ADDR_W];
    fields.rt = word[RT_LSB +: ADDR_W];
    fields.rd = word[RD_LSB +: ADDR_W];
    return fields;
  endfunction

endpackage

// File: rtl/alu_seq_fifo.sv
// alu_seq_fifo: small synchronous instruction FIFO with count-based
// full/empty flags. The head entry is presented on dout without waiting
// for a pop (first-word fall-through), so the sequencer can load it into
// its instruction register on the same edge that it pops.
module alu_seq_fifo
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = INSTR_W
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_en;
  logic             pop_en;
  logic [WIDTH-1:0] entry_data [DEPTH];

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  // Requests against a full/empty FIFO are ignored rather than corrupting state.
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign dout    = entry_data[rd_ptr_reg];

  // One storage slot per entry; only the slot under the write pointer loads.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] data_reg;

      // Capture the pushed word when this slot is the write target.
      always_ff @(posedge clk) begin
        if (push_en && (wr_ptr_reg == AW'(gi))) begin
          data_reg <= din;
        end
      end

      assign entry_data[gi] = data_reg;
    end
  endgenerate

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop_en) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push_en, pop_en})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: instruction sequencer for the register-file + ALU datapath.
// Buffers packed rr-instructions in a FIFO and walks each one through
// ISSUE (read + ALU evaluate, flags captured) and WRITE (write enable),
// pulsing done one cycle later with the captured flags.
// Optional feature: define ALU_SEQ_OF_GUARD_EN to suppress the register
// write of any instruction whose ALU result overflowed, and to raise a
// sticky err flag when that happens.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr_word,
  output logic [ADDR_W-1:0]  R_Addr_A,
  output logic [ADDR_W-1:0]  R_Addr_B,
  output logic [ADDR_W-1:0]  W_Addr,
  output logic [OP_W-1:0]    ALU_OP,
  output logic               Write_Reg,
  input  logic               OF,
  input  logic               ZF,
  output logic               done,
  output logic               done_of,
  output logic               done_zf,
  output logic               err,
  output logic               busy,
  output logic [CNT_W-1:0]   retired
);

  state_t             state_reg;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [INSTR_W-1:0] fifo_dout;
  instr_t             head_instr;
  logic               of_cap_reg;
  logic               zf_cap_reg;
  logic               wr_allow;

  alu_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .srst  (Reset),
    .push  (instr_valid),
    .pop   (fifo_pop),
    .din   (instr_word),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_instr  = instr_unpack(fifo_dout);
  assign instr_ready = !fifo_full;
  assign busy        = !fifo_empty || (state_reg != IDLE);
  // The next instruction is taken from IDLE, or straight out of WRITE so
  // that a full FIFO sustains one instruction every two cycles.
  assign fifo_pop    = (state_reg != ISSUE) && !fifo_empty;

`ifdef ALU_SEQ_OF_GUARD_EN
  logic err_reg;

  // An overflowing result is never committed to the register file.
  assign wr_allow = !OF;
  assign err      = err_reg;

  // Sticky overflow error: set by any overflow seen during ISSUE, cleared only by Reset.
  always_ff @(posedge clk) begin
    if (Reset) begin
      err_reg <= 1'b0;
    end else if ((state_reg == ISSUE) && OF) begin
      err_reg <= 1'b1;
    end
  end
`else
  assign wr_allow = 1'b1;
  assign err      = 1'b0;
`endif

  // Sequencer FSM: the address/opcode outputs double as the instruction
  // register, loaded on pop and held steady through ISSUE, WRITE and IDLE.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_reg  <= IDLE;
      R_Addr_A   <= '0;
      R_Addr_B   <= '0;
      W_Addr     <= '0;
      ALU_OP     <= '0;
      Write_Reg  <= 1'b0;
      of_cap_reg <= 1'b0;
      zf_cap_reg <= 1'b0;
      done       <= 1'b0;
      done_of    <= 1'b0;
      done_zf    <= 1'b0;
      retired    <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          Write_Reg <= 1'b0;
          if (fifo_pop) begin
            R_Addr_A  <= head_instr.rs;
            R_Addr_B  <= head_instr.rt;
            W_Addr    <= head_instr.rd;
            ALU_OP    <= head_instr.op;
            state_reg <= ISSUE;
          end
        end
        ISSUE: begin
          // Datapath settles combinationally during ISSUE; latch its flags now.
          of_cap_reg <= OF;
          zf_cap_reg <= ZF;
          Write_Reg  <= wr_allow;
          state_reg  <= WRITE;
        end
        WRITE: begin
          // Retire the instruction whose write commits at this edge.
          Write_Reg <= 1'b0;
          done      <= 1'b1;
          done_of   <= of_cap_reg;
          done_zf   <= zf_cap_reg;
          retired   <= retired + CNT_W'(1);
          if (fifo_pop) begin
            R_Addr_A  <= head_instr.rs;
            R_Addr_B  <= head_instr.rt;
            W_Addr    <= head_instr.rd;
            ALU_OP    <= head_instr.op;
            state_reg <= ISSUE;
          end else begin
            state_reg <= IDLE;
          end
        end
        default: begin
          Write_Reg <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
